// File: rtl/mccoy_program_sequencer.sv
// ---------------------------------------------------------------------------
// mccoy_program_sequencer
//
// Buffers a short McCoy program written by a loader and replays it into the
// core, one instruction per clock. The core is held in reset between runs.
// Its accumulator is captured once the last instruction has executed.
//
// Ports:
//   clk_i          system clock, all state updates on the rising edge
//   reset_n_i      asynchronous, active-low reset
//   wr_en_i        append wr_data_i to the program buffer
//   wr_data_i      instruction: [5:3] immediate/register field, [2:0] opcode
//   clear_i        empty the buffer and abort any run
//   start_i        begin playback of the stored program
//   core_out_i     core io_out; [5:0] is the accumulator
//   core_instr_o   instruction presented to the core (registered)
//   core_reset_o   active-high core reset (registered)
//   busy_o         a program is being issued or drained
//   done_o         the last run finished and result_o is valid
//   result_o       captured accumulator, two's complement
//   count_o        number of stored instructions, 0..DEPTH
//   err_o          sticky flag: a write was dropped
// ---------------------------------------------------------------------------
module mccoy_program_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          wr_en_i,
    input  logic [5:0]    wr_data_i,
    input  logic          clear_i,
    input  logic          start_i,
    input  logic [7:0]    core_out_i,
    output logic [5:0]    core_instr_o,
    output logic          core_reset_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [5:0]    result_o,
    output logic [AW:0]   count_o,
    output logic          err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    state_e      state_q, state_d;
    logic [AW:0] pc_q, pc_d;
    logic [AW:0] count_q, count_d;
    logic [5:0]  coreInstr_q, coreInstr_d;
    logic        coreReset_q, coreReset_d;
    logic        done_q, done_d;
    logic [5:0]  result_q, result_d;
    logic        err_q, err_d;
    logic        memWe;
    logic        canLoad;
    logic        startOk;

    logic [5:0]  mem_q [DEPTH];

    // The top two bits of io_out carry nothing the sequencer needs.
    logic        unusedCoreBits;
    assign unusedCoreBits = ^core_out_i[7:6];

    // State register and all registered outputs. Reset puts the core back
    // into reset immediately; the result is cleared only here.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            count_q     <= '0;
            coreInstr_q <= '0;
            coreReset_q <= 1'b1;
            done_q      <= 1'b0;
            result_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
            coreInstr_q <= coreInstr_d;
            coreReset_q <= coreReset_d;
            done_q      <= done_d;
            result_q    <= result_d;
            err_q       <= err_d;
        end
    end

    // Program storage has no reset: only count decides what is valid.
    always_ff @(posedge clk_i) begin
        if (memWe) begin
            mem_q[count_q[AW-1:0]] <= wr_data_i;
        end
    end

    // Next-state logic. Priority per edge is clear, then start, then write.
    // A write that cannot be honoured always raises the sticky error, except
    // under clear where it is swallowed silently.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        coreInstr_d = coreInstr_q;
        coreReset_d = coreReset_q;
        done_d      = done_q;
        result_d    = result_q;
        err_d       = err_q;
        memWe       = 1'b0;

        canLoad = (state_q == IDLE) || (state_q == DONE);
        startOk = start_i && canLoad && (count_q != '0);

        if (clear_i) begin
            state_d     = IDLE;
            pc_d        = '0;
            count_d     = '0;
            coreInstr_d = '0;
            coreReset_d = 1'b1;
            done_d      = 1'b0;
        end else if (startOk) begin
            state_d     = RUN;
            pc_d        = ONE;
            coreInstr_d = mem_q[0];
            coreReset_d = 1'b0;
            done_d      = 1'b0;
            if (wr_en_i) begin
                err_d = 1'b1;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (pc_q < count_q) begin
                        coreInstr_d = mem_q[pc_q[AW-1:0]];
                        pc_d        = pc_q + ONE;
                    end else begin
                        coreInstr_d = '0;
                        state_d     = DRAIN;
                    end
                end
                // The core executed the final instruction on the previous
                // edge, so its accumulator is stable now.
                DRAIN: begin
                    result_d    = core_out_i[5:0];
                    state_d     = DONE;
                    coreReset_d = 1'b1;
                    coreInstr_d = '0;
                    pc_d        = '0;
                    done_d      = 1'b1;
                end
                default: ;
            endcase

            if (wr_en_i) begin
                if (canLoad && (count_q < FULL)) begin
                    memWe   = 1'b1;
                    count_d = count_q + ONE;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    assign core_instr_o = coreInstr_q;
    assign core_reset_o = coreReset_q;
    assign busy_o       = (state_q == RUN) || (state_q == DRAIN);
    assign done_o       = done_q;
    assign result_o     = result_q;
    assign count_o      = count_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_mccoy_program_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mccoy_program_sequencer
//
// Drives the sequencer with directed programs and then random traffic. A
// small McCoy core stub supplies the core_out input. A behavioural model
// tracks the program list, the run position and the sticky flags, and
// predicts the outputs every cycle.
// ---------------------------------------------------------------------------
module tb_mccoy_program_sequencer;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic        wrEn = 1'b0;
    logic [5:0]  wrData = '0;
    logic        clearIn = 1'b0;
    logic        startIn = 1'b0;
    logic [7:0]  coreOut;
    logic [5:0]  coreInstr;
    logic        coreReset;
    logic        busy;
    logic        done;
    logic [5:0]  result;
    logic [4:0]  count;
    logic        err;

    int compared = 0;
    int mismatched = 0;
    bit checkEn = 1'b0;

    mccoy_program_sequencer #(.DEPTH(16), .AW(4)) dut (
        .clk_i        (clk),
        .reset_n_i    (resetN),
        .wr_en_i      (wrEn),
        .wr_data_i    (wrData),
        .clear_i      (clearIn),
        .start_i      (startIn),
        .core_out_i   (coreOut),
        .core_instr_o (coreInstr),
        .core_reset_o (coreReset),
        .busy_o       (busy),
        .done_o       (done),
        .result_o     (result),
        .count_o      (count),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    // McCoy core stub: li (000) loads a sign-extended immediate, sr (110)
    // stores the accumulator to a register, add (011) adds a register.
    // Every other opcode does nothing.
    logic [5:0] acc;
    logic [5:0] regs [8];
    assign coreOut = {2'b00, acc};

    always @(posedge clk) begin
        if (coreReset) begin
            acc <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            case (coreInstr[2:0])
                3'b000:  acc <= {{3{coreInstr[5]}}, coreInstr[5:3]};
                3'b110:  regs[coreInstr[5:3]] <= acc;
                3'b011:  acc <= acc + regs[coreInstr[5:3]];
                default: ;
            endcase
        end
    end

    // Final accumulator of a program run on a freshly reset core.
    function automatic logic [5:0] evalProgram(input logic [5:0] p [16], input int n);
        logic [5:0] a;
        logic [5:0] r [8];
        a = '0;
        for (int i = 0; i < 8; i++) r[i] = '0;
        for (int i = 0; i < n; i++) begin
            case (p[i][2:0])
                3'b000:  a = {{3{p[i][5]}}, p[i][5:3]};
                3'b110:  r[p[i][5:3]] = a;
                3'b011:  a = a + r[p[i][5:3]];
                default: ;
            endcase
        end
        return a;
    endfunction

    // Behavioural model. mK counts edges since the start edge: instruction
    // k is visible after edge k, edge n drains, edge n+1 captures the result.
    logic [5:0] mMem [16];
    int         mCount = 0;
    bit         mActive = 0;
    int         mK = 0;
    logic [5:0] mInstr = '0;
    bit         mCoreReset = 1;
    bit         mDone = 0;
    logic [5:0] mResult = '0;
    bit         mErr = 0;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mCount = 0; mActive = 0; mK = 0; mInstr = '0;
            mCoreReset = 1; mDone = 0; mResult = '0; mErr = 0;
        end else begin
            bit idleLike;
            idleLike = !mActive;
            if (clearIn) begin
                mCount = 0; mActive = 0; mInstr = '0; mCoreReset = 1; mDone = 0;
            end else if (startIn && idleLike && mCount > 0) begin
                mActive = 1; mK = 0; mInstr = mMem[0]; mCoreReset = 0; mDone = 0;
                if (wrEn) mErr = 1;
            end else begin
                if (mActive) begin
                    mK++;
                    if (mK < mCount) mInstr = mMem[mK];
                    else if (mK == mCount) mInstr = '0;
                    else begin
                        mResult = evalProgram(mMem, mCount);
                        mActive = 0; mDone = 1; mCoreReset = 1; mInstr = '0;
                    end
                end
                if (wrEn) begin
                    if (idleLike && mCount < 16) begin
                        mMem[mCount] = wrData;
                        mCount++;
                    end else begin
                        mErr = 1;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("coreInstr", coreInstr, mInstr);
            checkOutput("coreReset", coreReset, mCoreReset);
            checkOutput("busy", busy, mActive);
            checkOutput("done", done, mDone);
            checkOutput("result", result, mResult);
            checkOutput("count", count, mCount);
            checkOutput("err", err, mErr);
        end
    end

    // Holds the given inputs across exactly one rising edge, then releases.
    task automatic applyStimulus(input bit w, input logic [5:0] d, input bit c, input bit s);
        @(negedge clk);
        wrEn = w; wrData = d; clearIn = c; startIn = s;
        @(posedge clk);
        #1;
        wrEn = 0; wrData = '0; clearIn = 0; startIn = 0;
    endtask

    task automatic writeProgram(input logic [5:0] p [], input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, p[i], 0, 0);
    endtask

    // Called just after the start edge; counts edges until done rises.
    task automatic waitDone(input string name, input int expCycles);
        int k;
        k = 0;
        while (!done && k < 64) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!done) checkOutput({name, "Timeout"}, 0, 1);
        checkOutput(name, k, expCycles);
    endtask

    logic [5:0] prog1 [] = '{6'b011000, 6'b010110, 6'b010000, 6'b010011};
    logic [5:0] prog2 [] = '{6'b011000, 6'b010110, 6'b100000, 6'b011110,
                             6'b010000, 6'b010011, 6'b010000, 6'b011011};

    initial begin
        #2 resetN = 0;
        #10;
        checkOutput("resetCoreReset", coreReset, 1);
        checkOutput("resetCount", count, 0);
        checkOutput("resetBusy", busy, 0);
        @(negedge clk);
        resetN = 1;
        checkEn = 1;

        // Program 1: 4 instructions, result 5, done at E5.
        writeProgram(prog1, 4);
        checkOutput("prog1Count", count, 4);
        applyStimulus(0, '0, 0, 1);
        checkOutput("prog1Busy", busy, 1);
        checkOutput("prog1CoreReset", coreReset, 0);
        checkOutput("prog1FirstInstr", coreInstr, 6'b011000);
        waitDone("prog1Latency", 5);
        checkOutput("prog1Result", result, 5);
        checkOutput("prog1DoneCoreReset", coreReset, 1);

        // Replay from DONE, with a write during the run.
        applyStimulus(0, '0, 0, 1);
        applyStimulus(1, 6'b010000, 0, 0);
        waitDone("replayLatency", 4);
        checkOutput("replayResult", result, 5);
        checkOutput("runWriteErr", err, 1);
        checkOutput("runWriteCount", count, 4);

        // Program 2: negative result.
        applyStimulus(0, '0, 1, 0);
        writeProgram(prog2, 8);
        applyStimulus(0, '0, 0, 1);
        waitDone("prog2Latency", 9);
        checkOutput("prog2Result", result, 6'b111110);

        // clear + start in IDLE: nothing runs, buffer emptied.
        applyStimulus(0, '0, 1, 0);
        writeProgram(prog1, 4);
        applyStimulus(0, '0, 1, 1);
        checkOutput("clrStartCount", count, 0);
        checkOutput("clrStartBusy", busy, 0);
        checkOutput("clrStartCoreReset", coreReset, 1);

        // clear at E2 of a run: abort, result keeps program 2's value.
        writeProgram(prog1, 4);
        applyStimulus(0, '0, 0, 1);
        applyStimulus(0, '0, 0, 0);
        applyStimulus(0, '0, 1, 0);
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortDone", done, 0);
        checkOutput("abortCount", count, 0);
        checkOutput("abortCoreReset", coreReset, 1);
        checkOutput("abortResult", result, 6'b111110);

        // 17 writes into a 16-deep buffer, then a full-length run.
        for (int i = 0; i < 17; i++) applyStimulus(1, 6'($urandom_range(0, 63)), 0, 0);
        checkOutput("fullCount", count, 16);
        checkOutput("fullErr", err, 1);
        applyStimulus(0, '0, 0, 1);
        waitDone("fullLatency", 17);

        // Asynchronous reset in the middle of a run.
        applyStimulus(0, '0, 0, 1);
        @(posedge clk);
        #2 resetN = 0;
        #1;
        checkOutput("asyncCoreReset", coreReset, 1);
        checkOutput("asyncBusy", busy, 0);
        checkOutput("asyncCoreInstr", coreInstr, 0);
        checkOutput("asyncCount", count, 0);
        checkOutput("asyncResult", result, 0);
        checkOutput("asyncErr", err, 0);
        @(negedge clk);
        resetN = 1;
        applyStimulus(0, '0, 0, 1);
        checkOutput("emptyStartBusy", busy, 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            wrEn    = ($urandom_range(0, 99) < 35);
            wrData  = 6'($urandom_range(0, 63));
            clearIn = ($urandom_range(0, 99) < 2);
            startIn = ($urandom_range(0, 99) < 8);
        end
        @(negedge clk);
        wrEn = 0; clearIn = 0; startIn = 0;
        repeat (25) @(posedge clk);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
